// File: rtl/bike_mult_sequencer.sv
// bike_mult_sequencer: issues operand addresses for a block-wise BIKE
// polynomial multiply. The outer loop is the column and the inner loop is
// the row. The last-row flag and the column of each issue travel down a
// delay line that is as long as the datapath, so the result write lands
// when that column's accumulated word appears at the accumulator output.
module bike_mult_sequencer #(
   parameter int SIZE       = 5,
   parameter int NUM_BLOCKS = 20,
   parameter int PIPE_LAT   = 2
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            stall,
   output logic            busy,
   output logic            done,
   output logic            issue_valid,
   output logic [SIZE-1:0] addr_a,
   output logic [SIZE-1:0] addr_b,
   output logic            acc_clr,
   output logic            res_we,
   output logic [SIZE-1:0] res_addr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_FLUSH,
      S_DONE
   } state_t;

   localparam logic [SIZE-1:0] LAST_IDX   = SIZE'(NUM_BLOCKS - 1);
   // One extra bit so that col+row cannot overflow, even when NUM_BLOCKS == 2^SIZE.
   localparam logic [SIZE:0]   NB_EXT     = (SIZE+1)'(NUM_BLOCKS);
   localparam int              FCW        = 4;
   localparam logic [FCW-1:0]  FLUSH_LAST = FCW'(PIPE_LAT - 1);

   state_t          state_q;
   logic [SIZE-1:0] row_q;
   logic [SIZE-1:0] col_q;
   logic [SIZE-1:0] addr_b_q;
   logic [FCW-1:0]  flush_cnt_q;
   logic            busy_q;
   logic            done_q;

   logic            issue;
   logic            last_row;
   logic            last_col;
   logic            last_issue;
   logic [SIZE-1:0] row_d;
   logic [SIZE-1:0] col_d;
   logic [SIZE-1:0] addr_b_d;
   logic [SIZE:0]   sum_ext;

   assign issue      = (state_q == S_MULT) & ~stall;
   assign last_row   = (row_q == LAST_IDX);
   assign last_col   = (col_q == LAST_IDX);
   assign last_issue = issue & last_row & last_col;

   // Next row/col after this cycle's issue, and the matching rotated B address.
   always_comb begin
      row_d    = row_q;
      col_d    = col_q;
      sum_ext  = '0;
      addr_b_d = '0;
      if (issue) begin
         if (last_row) begin
            row_d = '0;
            col_d = last_col ? '0 : col_q + 1'b1;
         end else begin
            row_d = row_q + 1'b1;
         end
      end
      sum_ext = {1'b0, row_d} + {1'b0, col_d};
      if (sum_ext >= NB_EXT) begin
         addr_b_d = SIZE'(sum_ext - NB_EXT);
      end else begin
         addr_b_d = sum_ext[SIZE-1:0];
      end
   end

   // Control FSM with counters and registered busy/done.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         addr_b_q    <= '0;
         flush_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         row_q    <= row_d;
         col_q    <= col_d;
         addr_b_q <= addr_b_d;
         done_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_MULT;
                  busy_q  <= 1'b1;
               end
            end
            S_MULT: begin
               if (last_issue) begin
                  state_q     <= S_FLUSH;
                  flush_cnt_q <= '0;
               end
            end
            S_FLUSH: begin
               // Stall is deliberately ignored here: the datapath drains on a fixed schedule.
               if (flush_cnt_q == FLUSH_LAST) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  flush_cnt_q <= flush_cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The delay line has PIPE_LAT stages, and the final stage drives res_we/res_addr directly.
   genvar gi;
   generate
      for (gi = 0; gi < PIPE_LAT; gi++) begin : g_dl
         logic            stg_flag_q;
         logic [SIZE-1:0] stg_col_q;
         logic            stg_flag_d;
         logic [SIZE-1:0] stg_col_d;

         if (gi == 0) begin : g_head
            assign stg_flag_d = issue & last_row;
            assign stg_col_d  = col_q;
         end else begin : g_tail
            assign stg_flag_d = g_dl[gi-1].stg_flag_q;
            assign stg_col_d  = g_dl[gi-1].stg_col_q;
         end

         // Each stage shifts every cycle; stall only gates what enters stage 0.
         always_ff @(posedge clk) begin
            if (!resetn) begin
               stg_flag_q <= 1'b0;
               stg_col_q  <= '0;
            end else begin
               stg_flag_q <= stg_flag_d;
               stg_col_q  <= stg_col_d;
            end
         end
      end
   endgenerate

   assign busy        = busy_q;
   assign done        = done_q;
   assign issue_valid = issue;
   assign acc_clr     = issue & (row_q == '0);
   assign addr_a      = row_q;
   assign addr_b      = addr_b_q;
   assign res_we      = g_dl[PIPE_LAT-1].stg_flag_q;
   assign res_addr    = g_dl[PIPE_LAT-1].stg_col_q;

endmodule

// File: tb/tb_bike_mult_sequencer.sv
// Bench for bike_mult_sequencer. It drives two instances: a small one
// (4 blocks, SIZE=2, latency 2) and the default-size one (20 blocks,
// latency 3). A golden table, directed sequences and a behavioural model
// that runs on every cycle all check the outputs.
`timescale 1ns/1ps
module tb_bike_mult_sequencer;

   localparam int NA = 4;
   localparam int PA = 2;
   localparam int SA = 2;
   localparam int NB = 20;
   localparam int PB = 3;
   localparam int SB = 5;

   logic clk;
   logic a_resetn, a_start, a_stall, a_busy, a_done, a_iv, a_clr, a_we;
   logic [SA-1:0] a_addr_a, a_addr_b, a_res_addr;
   logic b_resetn, b_start, b_stall, b_busy, b_done, b_iv, b_clr, b_we;
   logic [SB-1:0] b_addr_a, b_addr_b, b_res_addr;

   int n_cmp;
   int n_bad;

   bike_mult_sequencer #(.SIZE(SA), .NUM_BLOCKS(NA), .PIPE_LAT(PA)) dut_a (
      .clk(clk), .resetn(a_resetn), .start(a_start), .stall(a_stall),
      .busy(a_busy), .done(a_done), .issue_valid(a_iv),
      .addr_a(a_addr_a), .addr_b(a_addr_b), .acc_clr(a_clr),
      .res_we(a_we), .res_addr(a_res_addr)
   );

   bike_mult_sequencer #(.SIZE(SB), .NUM_BLOCKS(NB), .PIPE_LAT(PB)) dut_b (
      .clk(clk), .resetn(b_resetn), .start(b_start), .stall(b_stall),
      .busy(b_busy), .done(b_done), .issue_valid(b_iv),
      .addr_a(b_addr_a), .addr_b(b_addr_b), .acc_clr(b_clr),
      .res_we(b_we), .res_addr(b_res_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Progress is tracked as an issue count k (row = k mod N, col = k div N).
   // Pending result writes sit in a calendar indexed by absolute cycle.
   int  m_n[2], m_p[2], m_phase[2], m_k[2], m_fl[2];
   bit  m_live[2];
   bit  cal_we[2][64];
   int  cal_col[2][64];
   int  cyc;

   function automatic logic in_rn(input int u);
      return (u == 0) ? a_resetn : b_resetn;
   endfunction
   function automatic logic in_start(input int u);
      return (u == 0) ? a_start : b_start;
   endfunction
   function automatic logic in_stall(input int u);
      return (u == 0) ? a_stall : b_stall;
   endfunction

   task automatic model_check(input int u, input logic [31:0] busy, input logic [31:0] done,
                              input logic [31:0] iv, input logic [31:0] clr, input logic [31:0] we,
                              input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] ra);
      int row, col, eiv, slot;
      string tag;
      if (!m_live[u]) return;
      tag  = (u == 0) ? "mA" : "mB";
      row  = m_k[u] % m_n[u];
      col  = m_k[u] / m_n[u];
      eiv  = (m_phase[u] == 1 && in_stall(u) == 1'b0) ? 1 : 0;
      slot = cyc % 64;
      check({tag, ".busy"}, busy, (m_phase[u] == 1 || m_phase[u] == 2) ? 1 : 0);
      check({tag, ".done"}, done, (m_phase[u] == 3) ? 1 : 0);
      check({tag, ".issue_valid"}, iv, eiv);
      check({tag, ".acc_clr"}, clr, (eiv == 1 && row == 0) ? 1 : 0);
      check({tag, ".addr_a"}, aa, row);
      check({tag, ".addr_b"}, ab, (row + col) % m_n[u]);
      check({tag, ".res_we"}, we, cal_we[u][slot] ? 1 : 0);
      if (cal_we[u][slot]) check({tag, ".res_addr"}, ra, cal_col[u][slot]);
   endtask

   task automatic model_step(input int u);
      int slot;
      slot = cyc % 64;
      if (in_rn(u) == 1'b0) begin
         m_live[u]  = 1'b1;
         m_phase[u] = 0;
         m_k[u]     = 0;
         m_fl[u]    = 0;
         for (int i = 0; i < 64; i++) cal_we[u][i] = 1'b0;
         return;
      end
      if (!m_live[u]) return;
      cal_we[u][slot] = 1'b0;
      case (m_phase[u])
         0: if (in_start(u) == 1'b1) m_phase[u] = 1;
         1: if (in_stall(u) == 1'b0) begin
               if (m_k[u] % m_n[u] == m_n[u] - 1) begin
                  cal_we[u][(cyc + m_p[u]) % 64]  = 1'b1;
                  cal_col[u][(cyc + m_p[u]) % 64] = m_k[u] / m_n[u];
               end
               m_k[u]++;
               if (m_k[u] == m_n[u] * m_n[u]) begin
                  m_k[u]     = 0;
                  m_phase[u] = 2;
                  m_fl[u]    = 0;
               end
            end
         2: begin
               m_fl[u]++;
               if (m_fl[u] == m_p[u]) m_phase[u] = 3;
            end
         default: m_phase[u] = 0;
      endcase
   endtask

   // The model compares on each falling edge and then advances with the inputs the next rising edge will sample.
   initial begin
      cyc = 0;
      m_n[0] = NA; m_p[0] = PA; m_n[1] = NB; m_p[1] = PB;
      for (int u = 0; u < 2; u++) begin
         m_live[u] = 1'b0; m_phase[u] = 0; m_k[u] = 0; m_fl[u] = 0;
         for (int i = 0; i < 64; i++) begin
            cal_we[u][i]  = 1'b0;
            cal_col[u][i] = 0;
         end
      end
      forever begin
         @(negedge clk);
         model_check(0, 32'(a_busy), 32'(a_done), 32'(a_iv), 32'(a_clr), 32'(a_we),
                     32'(a_addr_a), 32'(a_addr_b), 32'(a_res_addr));
         model_check(1, 32'(b_busy), 32'(b_done), 32'(b_iv), 32'(b_clr), 32'(b_we),
                     32'(b_addr_a), 32'(b_addr_b), 32'(b_res_addr));
         model_step(0);
         model_step(1);
         cyc++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step_a(input logic rn, input logic st, input logic sl);
      @(posedge clk);
      #1;
      a_resetn = rn; a_start = st; a_stall = sl;
      @(negedge clk);
   endtask

   task automatic step_b(input logic rn, input logic st, input logic sl);
      @(posedge clk);
      #1;
      b_resetn = rn; b_start = st; b_stall = sl;
      @(negedge clk);
   endtask

   int rec_wt[$];
   int rec_wa[$];
   int rec_iss, rec_done_t, rec_ndone;
   int ev[4];

   // The run on instance A starts at t=0 and holds stall high over [lo,hi]. It runs for a fixed cycle budget.
   task automatic run_a(input int lo, input int hi, input int budget);
      rec_wt.delete(); rec_wa.delete();
      rec_iss = 0; rec_done_t = -1; rec_ndone = 0;
      for (int t = 0; t < budget; t++) begin
         step_a(1'b1, (t == 0), (t >= lo && t <= hi));
         if (a_iv) rec_iss++;
         if (a_we) begin
            rec_wt.push_back(t);
            rec_wa.push_back(int'(a_res_addr));
         end
         if (a_done) begin
            rec_ndone++;
            if (rec_done_t < 0) rec_done_t = t;
         end
      end
   endtask

   task automatic check_seq(input string name, input int got[$], input int expv[4], input int n);
      check({name, ".count"}, got.size(), n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s[%0d]", name, i), (i < got.size()) ? got[i] : -1, expv[i]);
      end
   endtask

   typedef struct {
      int start, stall, busy, done, iv, clr, we, a, b, ra;
   } vec_t;
   vec_t tbl[21];

   initial begin
      int dq[$];
      int iq[$];
      int prev_iv, tail_done, tail_t;
      int niss, nclr, maxb, blast, nwe, lastra, done_t;

      n_cmp = 0; n_bad = 0;
      a_resetn = 1'b0; a_start = 1'b0; a_stall = 1'b0;
      b_resetn = 1'b0; b_start = 1'b0; b_stall = 1'b0;

      // Fields: start, stall | busy, done, issue_valid, acc_clr, res_we, addr_a, addr_b, res_addr
      tbl[0]  = '{1,0, 0,0,0,0,0, 0,0,0};
      tbl[1]  = '{0,0, 1,0,1,1,0, 0,0,0};
      tbl[2]  = '{0,0, 1,0,1,0,0, 1,1,0};
      tbl[3]  = '{0,0, 1,0,1,0,0, 2,2,0};
      tbl[4]  = '{0,0, 1,0,1,0,0, 3,3,0};
      tbl[5]  = '{0,0, 1,0,1,1,0, 0,1,0};
      tbl[6]  = '{0,0, 1,0,1,0,1, 1,2,0};
      tbl[7]  = '{0,0, 1,0,1,0,0, 2,3,0};
      tbl[8]  = '{0,0, 1,0,1,0,0, 3,0,0};
      tbl[9]  = '{0,0, 1,0,1,1,0, 0,2,0};
      tbl[10] = '{0,0, 1,0,1,0,1, 1,3,1};
      tbl[11] = '{0,0, 1,0,1,0,0, 2,0,0};
      tbl[12] = '{0,0, 1,0,1,0,0, 3,1,0};
      tbl[13] = '{0,0, 1,0,1,1,0, 0,3,0};
      tbl[14] = '{0,0, 1,0,1,0,1, 1,0,2};
      tbl[15] = '{0,0, 1,0,1,0,0, 2,1,0};
      tbl[16] = '{0,0, 1,0,1,0,0, 3,2,0};
      tbl[17] = '{0,0, 1,0,0,0,0, 0,0,0};
      tbl[18] = '{0,0, 1,0,0,0,1, 0,0,3};
      tbl[19] = '{0,0, 0,1,0,0,0, 0,0,0};
      tbl[20] = '{0,0, 0,0,0,0,0, 0,0,0};

      repeat (3) @(posedge clk);
      #1;
      a_resetn = 1'b1; b_resetn = 1'b1;
      @(negedge clk);
      check("reset_a", 32'({a_busy, a_done, a_iv, a_clr, a_we, a_addr_a, a_addr_b, a_res_addr}), 0);
      check("reset_b", 32'({b_busy, b_done, b_iv, b_clr, b_we, b_addr_a, b_addr_b, b_res_addr}), 0);
      step_a(1'b1, 1'b0, 1'b0);

      $display("scenario: golden table, 4 blocks, no stall");
      for (int i = 0; i < 21; i++) begin
         step_a(1'b1, (tbl[i].start != 0), (tbl[i].stall != 0));
         check($sformatf("tbl[%0d].busy", i), 32'(a_busy), tbl[i].busy);
         check($sformatf("tbl[%0d].done", i), 32'(a_done), tbl[i].done);
         check($sformatf("tbl[%0d].issue_valid", i), 32'(a_iv), tbl[i].iv);
         check($sformatf("tbl[%0d].acc_clr", i), 32'(a_clr), tbl[i].clr);
         check($sformatf("tbl[%0d].res_we", i), 32'(a_we), tbl[i].we);
         check($sformatf("tbl[%0d].addr_a", i), 32'(a_addr_a), tbl[i].a);
         check($sformatf("tbl[%0d].addr_b", i), 32'(a_addr_b), tbl[i].b);
         if (tbl[i].we != 0) check($sformatf("tbl[%0d].res_addr", i), 32'(a_res_addr), tbl[i].ra);
      end

      $display("scenario: stall cycles 5..7 during MULT");
      run_a(5, 7, 30);
      check("stall.issues", rec_iss, 16);
      check("stall.done_t", rec_done_t, 22);
      check("stall.ndone", rec_ndone, 1);
      ev = '{6, 13, 17, 21};
      check_seq("stall.we_t", rec_wt, ev, 4);
      ev = '{0, 1, 2, 3};
      check_seq("stall.we_addr", rec_wa, ev, 4);

      $display("scenario: stall held through FLUSH");
      run_a(17, 29, 30);
      check("fstall.issues", rec_iss, 16);
      check("fstall.done_t", rec_done_t, 19);
      ev = '{6, 10, 14, 18};
      check_seq("fstall.we_t", rec_wt, ev, 4);
      ev = '{0, 1, 2, 3};
      check_seq("fstall.we_addr", rec_wa, ev, 4);

      $display("scenario: reset during MULT at col=2");
      for (int t = 0; t < 9; t++) step_a(1'b1, (t == 0), 1'b0);
      step_a(1'b0, 1'b0, 1'b0);
      check("rst.busy_before", 32'(a_busy), 1);
      check("rst.addr_a_before", 32'(a_addr_a), 0);
      check("rst.addr_b_before", 32'(a_addr_b), 2);
      for (int t = 10; t < 18; t++) begin
         step_a(1'b1, 1'b0, 1'b0);
         check($sformatf("rst.quiet_t%0d", t),
               32'({a_busy, a_done, a_iv, a_clr, a_we, a_addr_a, a_addr_b, a_res_addr}), 0);
      end

      $display("scenario: start held high, back-to-back runs");
      prev_iv = 0;
      for (int t = 0; t < 50; t++) begin
         step_a(1'b1, 1'b1, 1'b0);
         if (a_iv && prev_iv == 0) iq.push_back(t);
         prev_iv = a_iv ? 1 : 0;
         if (a_done) dq.push_back(t);
      end
      ev = '{19, 39, 0, 0};
      check_seq("b2b.done_t", dq, ev, 2);
      ev = '{1, 21, 41, 0};
      check_seq("b2b.first_issue_t", iq, ev, 3);
      tail_done = 0; tail_t = -1;
      for (int t = 50; t < 75; t++) begin
         step_a(1'b1, 1'b0, 1'b0);
         if (a_done) begin
            tail_done++;
            tail_t = t;
         end
      end
      check("b2b.tail_ndone", tail_done, 1);
      check("b2b.tail_done_t", tail_t, 59);

      $display("scenario: 20 blocks, wrap and acc_clr count");
      niss = 0; nclr = 0; maxb = 0; blast = -1; nwe = 0; lastra = -1; done_t = -1;
      for (int t = 0; t < 420; t++) begin
         step_b(1'b1, (t == 0), 1'b0);
         if (b_clr) nclr++;
         if (b_iv) begin
            niss++;
            if (int'(b_addr_b) > maxb) maxb = int'(b_addr_b);
            if (niss == 400 && b_addr_a == 5'd19) blast = int'(b_addr_b);
         end
         if (b_we) begin
            nwe++;
            lastra = int'(b_res_addr);
         end
         if (b_done && done_t < 0) done_t = t;
      end
      check("wrap.issues", niss, 400);
      check("wrap.acc_clr_count", nclr, 20);
      check("wrap.max_addr_b", maxb, 19);
      check("wrap.addr_b_r19c19", blast, 18);
      check("wrap.writes", nwe, 20);
      check("wrap.last_res_addr", lastra, 19);
      check("wrap.done_t", done_t, 404);

      $display("scenario: randomized start/stall/reset on both instances");
      for (int t = 0; t < 3000; t++) begin
         @(posedge clk);
         #1;
         a_resetn = ($urandom_range(0, 299) != 0);
         a_start  = ($urandom_range(0, 3) == 0);
         a_stall  = ($urandom_range(0, 2) == 0);
         b_resetn = ($urandom_range(0, 999) != 0);
         b_start  = ($urandom_range(0, 3) == 0);
         b_stall  = ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end

      @(posedge clk);
      #1;
      a_start = 1'b0; b_start = 1'b0;
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bike_mult_sequencer.md
Name: bike_mult_sequencer

Overview:
- Controller that sequences a block-wise BIKE polynomial multiplication over NUM_BLOCKS memory words.
- Generates operand/result addresses, accumulator clear and result write-enable for the multiplier datapath.
- Built from a nested row/column counter pair plus a valid delay line that matches the datapath latency.
- Sits between the top-level BIKE control FSM (start/done handshake) and the BRAM-based multiplier core.

Parameters:
- SIZE, 5, address/counter width in bits; must satisfy 2^SIZE >= NUM_BLOCKS.
- NUM_BLOCKS, 20, number of polynomial words; valid range 2 to 2^SIZE.
- PIPE_LAT, 2, cycles from an operand issue to that word's result at the accumulator output; valid range 1 to 8.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- resetn, input, 1, synchronous active-low reset.
- start, input, 1, request a multiplication; sampled only in IDLE.
- stall, input, 1, freezes issue while high (MULT state only).
- busy, output, 1, high in MULT and FLUSH.
- done, output, 1, single-cycle pulse when all results are written.
- issue_valid, output, 1, operand addresses valid this cycle.
- addr_a, output, SIZE, operand A word address (row).
- addr_b, output, SIZE, operand B word address, (col+row) mod NUM_BLOCKS.
- acc_clr, output, 1, accumulator clear, coincident with each row==0 issue.
- res_we, output, 1, result write enable.
- res_addr, output, SIZE, result word address (column).

Behaviour:
- Reset: on a clk edge with resetn=0, the block enters IDLE. Row, col, all outputs and the delay line clear to 0. Reset mid-operation discards pending writes; no res_we or done follows.
- FSM states: IDLE, MULT, FLUSH, DONE.
- IDLE → MULT on start=1. row=0, col=0.
- MULT issue rule: issue_valid = ~stall. addr_a=row. addr_b=(col+row) wraps at NUM_BLOCKS with no overflow beyond NUM_BLOCKS-1; computed with SIZE+1-bit intermediate. acc_clr = issue_valid & (row==0).
- MULT counters: on an issue, row increments. At row==NUM_BLOCKS-1, row wraps to 0 and col increments.
- MULT exit: the issue with row==NUM_BLOCKS-1 and col==NUM_BLOCKS-1 moves the FSM to FLUSH.
- MULT with stall=1: row, col and state hold. issue_valid=0, acc_clr=0.
- Delay line: PIPE_LAT stages of {last_row_flag, col} shifting every cycle, regardless of stall.
- Result write: res_we asserts exactly PIPE_LAT cycles after an issue with row==NUM_BLOCKS-1. res_addr is that issue's col.
- FLUSH: counts PIPE_LAT cycles, then goes to DONE. stall is ignored.
- DONE: done=1 for one cycle, then IDLE. busy=0 in DONE and IDLE.
- start outside IDLE is ignored; no queuing. start held high in DONE's following IDLE cycle launches a new run.
- Outputs are registered except issue_valid/acc_clr, which are combinational from state, stall and row.
- Unstalled latency: start at cycle t gives first issue at t+1, last issue at t+NUM_BLOCKS², last res_we at t+NUM_BLOCKS²+PIPE_LAT, done at t+NUM_BLOCKS²+PIPE_LAT+1.

Test Plan:
- NUM_BLOCKS=4, PIPE_LAT=2, start pulse at t=0, no stall → 16 issues t=1..16; addr_b sequence for col=1 is 1,2,3,0; res_we at t=6,10,14,18 with res_addr 0,1,2,3; done only at t=19; busy t=1..18.
- Same config, stall=1 for cycles 5..7 → issue_valid low for those 3 cycles, row/col frozen; done at t=22; res_addr order unchanged; no duplicate or missing writes.
- Wrap check with NUM_BLOCKS=20, SIZE=5, col=19, row=19 → addr_b=18, never >=20; acc_clr asserted exactly 20 times per run.
- resetn=0 for one cycle during MULT at col=2 → next cycle IDLE, all outputs 0; no res_we or done afterwards even across PIPE_LAT cycles.
- start held high continuously → runs back-to-back, one IDLE cycle between done and the next first issue; start during MULT/FLUSH has no effect.
- stall=1 while in FLUSH → FLUSH still lasts exactly PIPE_LAT cycles; pending res_we pulses still emitted on schedule.
